// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic/shift/move ops plus iterative
// multiply and restoring divide that write the HI/LO register pair.
module seq_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [20:0]      alu_control,
  input  logic [WIDTH-1:0] alu_src1,
  input  logic [WIDTH-1:0] alu_src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;          // {remainder/partial product, quotient/multiplier}
  logic [WIDTH-1:0]   d_q, d_d;          // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_q, a_d;          // raw dividend, needed for divide by zero
  logic               mul_q, mul_d;
  logic               neg_prod_q, neg_prod_d;  // negate product or quotient at the end
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic             accept, onehot, is_mul, is_div, signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] sc_res, sum, diff;
  logic             sc_ovf;

  assign in_ready   = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == StDone);
  assign alu_result = result_q;
  assign overflow   = ovf_q;
  assign hi         = hi_q;
  assign lo         = lo_q;

  assign onehot    = (alu_control != '0) && ((alu_control & (alu_control - 21'd1)) == '0);
  assign is_mul    = onehot && (alu_control[13] || alu_control[14]);
  assign is_div    = onehot && (alu_control[15] || alu_control[16]);
  assign signed_op = alu_control[13] || alu_control[15];
  assign a_neg     = signed_op && alu_src1[WIDTH-1];
  assign b_neg     = signed_op && alu_src2[WIDTH-1];
  assign a_mag     = a_neg ? -alu_src1 : alu_src1;
  assign b_mag     = b_neg ? -alu_src2 : alu_src2;
  assign sum       = alu_src1 + alu_src2;
  assign diff      = alu_src1 - alu_src2;

  // Single-cycle result; malformed control words fall through to zero.
  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    if (onehot) begin
      unique case (1'b1)
        alu_control[0]: begin
          sc_res = sum;
          sc_ovf = (alu_src1[WIDTH-1] == alu_src2[WIDTH-1]) && (sum[WIDTH-1] != alu_src1[WIDTH-1]);
        end
        alu_control[1]: begin
          sc_res = diff;
          sc_ovf = (alu_src1[WIDTH-1] != alu_src2[WIDTH-1]) &&
                   (diff[WIDTH-1] != alu_src1[WIDTH-1]);
        end
        alu_control[2]:  sc_res = {{(WIDTH-1){1'b0}}, $signed(alu_src1) < $signed(alu_src2)};
        alu_control[3]:  sc_res = {{(WIDTH-1){1'b0}}, alu_src1 < alu_src2};
        alu_control[4]:  sc_res = alu_src1 & alu_src2;
        alu_control[5]:  sc_res = ~(alu_src1 | alu_src2);
        alu_control[6]:  sc_res = alu_src1 | alu_src2;
        alu_control[7]:  sc_res = alu_src1 ^ alu_src2;
        alu_control[8]:  sc_res = alu_src2 << alu_src1[SHW-1:0];
        alu_control[9]:  sc_res = alu_src2 >> alu_src1[SHW-1:0];
        alu_control[10]: sc_res = $signed(alu_src2) >>> alu_src1[SHW-1:0];
        alu_control[11]: sc_res = {alu_src2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
        alu_control[12]: sc_res = {{(WIDTH/2){1'b0}}, alu_src2[WIDTH-1:WIDTH/2]};
        alu_control[17]: sc_res = hi_q;
        alu_control[18]: sc_res = lo_q;
        alu_control[19]: sc_res = alu_src1;
        alu_control[20]: sc_res = alu_src1;
        default:         sc_res = '0;
      endcase
    end
  end

  logic [WIDTH:0]     mul_sum, div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem, quo, rem, fin_hi, fin_lo;
  logic [2*WIDTH-1:0] p_step, prod;

  // One iteration of shift-add multiply or restoring divide, plus final sign fix-up.
  always_comb begin
    mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, d_q} : '0);
    div_sh  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    div_ge  = div_sh >= {1'b0, d_q};
    div_rem = div_ge ? (div_sh[WIDTH-1:0] - d_q) : div_sh[WIDTH-1:0];
    p_step  = mul_q ? {mul_sum, p_q[WIDTH-1:1]} : {div_rem, p_q[WIDTH-2:0], div_ge};
    prod    = neg_prod_q ? -p_step : p_step;
    quo     = neg_prod_q ? -p_step[WIDTH-1:0] : p_step[WIDTH-1:0];
    rem     = neg_rem_q ? -p_step[2*WIDTH-1:WIDTH] : p_step[2*WIDTH-1:WIDTH];
    if (mul_q) begin
      fin_hi = prod[2*WIDTH-1:WIDTH];
      fin_lo = prod[WIDTH-1:0];
    end else if (div0_q) begin
      fin_hi = a_q;
      fin_lo = '1;
    end else begin
      fin_hi = rem;
      fin_lo = quo;
    end
  end

  // FSM next state and register updates; hi/lo only move on DONE entry.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    d_d        = d_q;
    a_d        = a_q;
    mul_d      = mul_q;
    neg_prod_d = neg_prod_q;
    neg_rem_d  = neg_rem_q;
    div0_d     = div0_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    unique case (state_q)
      StBusy: begin
        p_d   = p_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d  = StDone;
          cnt_d    = '0;
          hi_d     = fin_hi;
          lo_d     = fin_lo;
          result_d = fin_lo;
          ovf_d    = 1'b0;
        end
      end
      StDone: if (out_ready) state_d = StIdle;
      default: ;
    endcase

    if (accept) begin
      if (is_mul || is_div) begin
        state_d    = StBusy;
        cnt_d      = '0;
        p_d        = {{WIDTH{1'b0}}, a_mag};
        d_d        = b_mag;
        a_d        = alu_src1;
        mul_d      = is_mul;
        neg_prod_d = a_neg ^ b_neg;
        neg_rem_d  = a_neg;
        div0_d     = is_div && (alu_src2 == '0);
      end else begin
        state_d  = StDone;
        result_d = sc_res;
        ovf_d    = sc_ovf;
        if (onehot && alu_control[19]) hi_d = alu_src1;
        if (onehot && alu_control[20]) lo_d = alu_src1;
      end
    end
  end

  // State register with synchronous reset that wins over any accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      p_q        <= '0;
      d_q        <= '0;
      a_q        <= '0;
      mul_q      <= 1'b0;
      neg_prod_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div0_q     <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      d_q        <= d_d;
      a_q        <= a_d;
      mul_q      <= mul_d;
      neg_prod_q <= neg_prod_d;
      neg_rem_q  <= neg_rem_d;
      div0_q     <= div0_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH = 32.
module tb_seq_alu;
  localparam int W = 32;
  localparam logic [20:0] C_ADD  = 21'h000001, C_SUB  = 21'h000002, C_SLT  = 21'h000004;
  localparam logic [20:0] C_SLTU = 21'h000008, C_AND  = 21'h000010, C_NOR  = 21'h000020;
  localparam logic [20:0] C_OR   = 21'h000040, C_XOR  = 21'h000080, C_SLL  = 21'h000100;
  localparam logic [20:0] C_SRL  = 21'h000200, C_SRA  = 21'h000400, C_LUI  = 21'h000800;
  localparam logic [20:0] C_LLO  = 21'h001000, C_MULT = 21'h002000, C_MULTU = 21'h004000;
  localparam logic [20:0] C_DIV  = 21'h008000, C_DIVU = 21'h010000, C_MFHI = 21'h020000;
  localparam logic [20:0] C_MFLO = 21'h040000, C_MTHI = 21'h080000, C_MTLO = 21'h100000;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready, overflow;
  logic [20:0]  alu_control;
  logic [W-1:0] alu_src1, alu_src2, alu_result, hi, lo;
  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .overflow(overflow), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Present one request for one edge; returns just after the accept edge.
  task automatic send(input logic [20:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in_valid = 1'b1; alu_control = ctl; alu_src1 = a; alu_src2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Cycles from accept until out_valid, bounded.
  task automatic wait_out(output int n);
    n = 1;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_control = '0; alu_src1 = '0; alu_src2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    checks++;
    if ({in_ready, out_valid, overflow} !== 3'b100) begin
      errors++; $display("FAIL reset_flags: got %b want 100", {in_ready, out_valid, overflow});
    end
    checks++;
    if ({alu_result, hi, lo} !== {3*W{1'b0}}) begin
      errors++; $display("FAIL reset_regs: got %h %h %h want all zero", alu_result, hi, lo);
    end
  endtask

  task automatic test_add_overflow;
    int n;
    logic [20:0]  ctl[4];
    logic [W-1:0] a[4], b[4], e[4];
    logic         eo[4];
    ctl = '{C_ADD, C_ADD, C_SUB, C_ADD};
    a   = '{32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h00000005};
    b   = '{32'h00000001, 32'h80000000, 32'h00000001, 32'h00000003};
    e   = '{32'h80000000, 32'h00000000, 32'h7FFFFFFF, 32'h00000008};
    eo  = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      send(ctl[i], a[i], b[i]);
      wait_out(n);
      checks++;
      if (n != 1 || alu_result !== e[i] || overflow !== eo[i]) begin
        errors++;
        $display("FAIL add_sub[%0d]: got lat %0d res %h ovf %b want lat 1 res %h ovf %b",
                 i, n, alu_result, overflow, e[i], eo[i]);
      end
    end
  endtask

  task automatic test_alu_ops;
    int n;
    logic [20:0]  ctl[10];
    logic [W-1:0] a[10], b[10], e[10];
    ctl = '{C_SUB, C_SLT, C_SLTU, C_NOR, C_XOR, C_SLL, C_SRL, C_LUI, C_LLO, C_SLL};
    a = '{32'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'hFF00FF00,
          32'd4, 32'd4, 32'd0, 32'd0, 32'h24};
    b = '{32'd3, 32'd1, 32'd1, 32'h00FF00FF, 32'h0FF00FF0,
          32'd1, 32'h80000000, 32'h00001234, 32'hABCD0000, 32'h3};
    e = '{32'd7, 32'd1, 32'd0, 32'hF000F000, 32'hF0F0F0F0,
          32'h10, 32'h08000000, 32'h12340000, 32'h0000ABCD, 32'h30};
    for (int i = 0; i < 10; i++) begin
      send(ctl[i], a[i], b[i]);
      wait_out(n);
      checks++;
      if (n != 1 || alu_result !== e[i] || overflow !== 1'b0) begin
        errors++;
        $display("FAIL alu_op[%0d]: got lat %0d res %h ovf %b want lat 1 res %h ovf 0",
                 i, n, alu_result, overflow, e[i]);
      end
    end
  endtask

  task automatic test_move;
    send(C_MTHI, 32'hDEAD0001, 32'h0);
    checks++;
    if (alu_result !== 32'hDEAD0001 || hi !== 32'hDEAD0001) begin
      errors++; $display("FAIL mthi: got res %h hi %h want DEAD0001", alu_result, hi);
    end
    send(C_MTLO, 32'h12345678, 32'h0);
    checks++;
    if (alu_result !== 32'h12345678 || lo !== 32'h12345678 || hi !== 32'hDEAD0001) begin
      errors++; $display("FAIL mtlo: got res %h lo %h hi %h want 12345678 12345678 DEAD0001",
                         alu_result, lo, hi);
    end
    send(C_MFHI, 32'h0, 32'h0);
    checks++;
    if (alu_result !== 32'hDEAD0001) begin
      errors++; $display("FAIL mfhi: got %h want DEAD0001", alu_result);
    end
    send(C_MFLO, 32'h0, 32'h0);
    checks++;
    if (alu_result !== 32'h12345678) begin
      errors++; $display("FAIL mflo: got %h want 12345678", alu_result);
    end
  endtask

  task automatic test_invalid;
    int n;
    logic [20:0] ctl[3];
    ctl = '{21'h000000, C_ADD | C_SUB, C_MULT | C_DIV};
    for (int i = 0; i < 3; i++) begin
      send(ctl[i], 32'hFFFFFFFF, 32'h7FFFFFFF);
      wait_out(n);
      checks++;
      if (n != 1 || alu_result !== '0 || overflow !== 1'b0 || hi !== 32'hDEAD0001 ||
          lo !== 32'h12345678) begin
        errors++;
        $display("FAIL invalid[%0d]: got lat %0d res %h ovf %b hi %h lo %h want 1 0 0 DEAD0001 12345678",
                 i, n, alu_result, overflow, hi, lo);
      end
    end
  endtask

  task automatic test_muldiv;
    int n;
    logic [20:0]  ctl[10];
    logic [W-1:0] a[10], b[10], ehi[10], elo[10];
    ctl = '{C_MULT, C_MULTU, C_MULT, C_MULTU, C_DIV, C_DIVU, C_DIV, C_DIV, C_DIVU, C_DIV};
    a   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9,
            32'd7, 32'h80000000, 32'd7, 32'd100, 32'hFFFFFFF9};
    b   = '{32'd2, 32'd2, 32'd5, 32'hFFFFFFFF, 32'd2,
            32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd7, 32'd0};
    ehi = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF,
            32'h00000007, 32'h00000000, 32'h00000001, 32'h00000002, 32'hFFFFFFF9};
    elo = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFF1, 32'h00000001, 32'hFFFFFFFD,
            32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFD, 32'h0000000E, 32'hFFFFFFFF};
    for (int i = 0; i < 10; i++) begin
      send(ctl[i], a[i], b[i]);
      wait_out(n);
      checks++;
      if (n != 33 || hi !== ehi[i] || lo !== elo[i] || alu_result !== elo[i] ||
          overflow !== 1'b0) begin
        errors++;
        $display("FAIL muldiv[%0d]: got lat %0d hi %h lo %h res %h want lat 33 hi %h lo %h",
                 i, n, hi, lo, alu_result, ehi[i], elo[i]);
      end
    end
  endtask

  task automatic test_hold;
    @(posedge clk); #1;
    send(C_SRA, 32'd4, 32'h80000000);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; alu_control = C_ADD; alu_src1 = 32'd1; alu_src2 = 32'd1;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b10 || alu_result !== 32'hF8000000) begin
        errors++; $display("FAIL hold[%0d]: got v/r %b res %h want 10 F8000000",
                           i, {out_valid, in_ready}, alu_result);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || alu_result !== 32'hF8000000) begin
      errors++; $display("FAIL hold_release: got v %b res %h want 0 F8000000",
                         out_valid, alu_result);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    in_valid = 1'b1; alu_control = C_AND; alu_src1 = 32'h0F; alu_src2 = 32'hFF;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || alu_result !== 32'h0F) begin
      errors++; $display("FAIL b2b_and: got v %b res %h want 1 0000000F", out_valid, alu_result);
    end
    @(negedge clk);
    alu_control = C_OR;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || alu_result !== 32'hFF) begin
      errors++; $display("FAIL b2b_or: got v %b res %h want 1 000000FF", out_valid, alu_result);
    end
  endtask

  task automatic test_reset_abort;
    logic seen;
    send(C_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10 || hi !== '0 || lo !== '0 || alu_result !== '0) begin
      errors++; $display("FAIL abort_state: got r/v %b hi %h lo %h res %h want 10 0 0 0",
                         {in_ready, out_valid}, hi, lo, alu_result);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || hi !== '0 || lo !== '0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abort_quiet: got activity %b want 0", seen);
    end
    send(C_MFHI, 32'h0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || alu_result !== '0) begin
      errors++; $display("FAIL abort_mfhi: got v %b res %h want 1 0", out_valid, alu_result);
    end
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; alu_control = C_MTLO; alu_src1 = 32'h55;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    checks++;
    if (lo !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_priority: got lo %h v %b r %b want 0 0 1",
                         lo, out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_alu_ops();
    test_move();
    test_invalid();
    test_muldiv();
    test_hold();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; power of two, 8..64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-007 SHALL have port alu_control  input  21  one-hot op: 0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 nor, 6 or, 7 xor, 8 sll, 9 srl, 10 sra, 11 lui, 12 llo, 13 mult, 14 multu, 15 div, 16 divu, 17 mfhi, 18 mflo, 19 mthi, 20 mtlo.
REQ-008 SHALL have ports alu_src1, alu_src2  input  WIDTH each  operands.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port alu_result  output  WIDTH  registered result.
REQ-012 SHALL have port overflow  output  1  signed overflow of add/sub; 0 for all other ops.
REQ-013 SHALL have ports hi, lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-014 SHALL accept a request when in_valid && in_ready; operands and control captured that edge.
REQ-015 SHALL implement FSM IDLE, BUSY, DONE; in_ready = (state==IDLE) || (state==DONE && out_ready).
REQ-016 Ops 0-12 and 17-20 SHALL go accept -> DONE, out_valid on the next cycle (latency 1).
REQ-017 Ops 13-16 SHALL go accept -> BUSY for exactly WIDTH cycles (iterative shift-add / restoring divide, one bit per cycle) -> DONE; out_valid WIDTH+1 cycles after accept.
REQ-018 DONE SHALL hold out_valid, alu_result, overflow stable until out_ready; then IDLE, or straight to new op if a request is accepted the same cycle.
REQ-019 Add/sub SHALL wrap modulo 2^WIDTH; overflow = operands' signs (src2 inverted for sub) equal and result sign differs.
REQ-020 slt/sltu SHALL return 1 or 0 zero-extended to WIDTH (signed / unsigned src1 < src2).
REQ-021 Shifts SHALL shift src2 by src1[SHW-1:0]; sra sign-fills.
REQ-022 lui SHALL return {src2[WIDTH/2-1:0], zeros}; llo SHALL return {zeros, src2[WIDTH-1:WIDTH/2]}.
REQ-023 mult/multu SHALL write full 2*WIDTH product: hi = upper half, lo = lower half; alu_result = lo.
REQ-024 div/divu SHALL write lo = quotient, hi = remainder; signed: quotient truncates toward zero, remainder takes dividend sign; alu_result = lo.
REQ-025 Divide by zero SHALL give lo = all ones, hi = src1, no extra cycles.
REQ-026 Signed div of most-negative by -1 SHALL give lo = most-negative, hi = 0.
REQ-027 mfhi/mflo SHALL return current hi/lo; mthi/mtlo SHALL load hi/lo from src1 and return src1.
REQ-028 hi/lo SHALL change only at the DONE-entry edge of ops 13-16, 19, 20.
REQ-029 alu_control with zero or >1 bits set SHALL complete with latency 1, alu_result 0, overflow 0, hi/lo unchanged.
REQ-030 in_valid while BUSY or DONE-without-out_ready SHALL be ignored (not accepted, not queued).

Reset
REQ-031 Reset SHALL force IDLE, in_ready 1, out_valid 0, alu_result 0, overflow 0, hi 0, lo 0, iteration counter 0.
REQ-032 Reset asserted in BUSY or DONE SHALL abort the op; no hi/lo update, no out_valid on the following cycle.
REQ-033 Reset SHALL take priority over any simultaneous accept.

Verification
REQ-034 add 0x7FFFFFFF + 0x00000001, out_ready=1 -> next cycle out_valid, result 0x80000000, overflow 1.
REQ-035 mult 0xFFFFFFFF x 0x00000002 (signed) -> out_valid exactly 33 cycles after accept, hi 0xFFFFFFFF, lo 0xFFFFFFFE; multu same operands -> hi 0x00000001, lo 0xFFFFFFFE.
REQ-036 div -7 / 2 -> lo 0xFFFFFFFD, hi 0xFFFFFFFF; divu 7 / 0 -> lo 0xFFFFFFFF, hi 0x00000007.
REQ-037 out_ready held 0 for 5 cycles after sra 0x80000000 by 4 -> result 0xF8000000 stable, in_ready 0; new in_valid ignored until out_ready.
REQ-038 reset pulsed at BUSY cycle 10 of a div -> IDLE next cycle, hi/lo 0, out_valid 0; subsequent mfhi returns 0.
REQ-039 Back-to-back and, or with out_ready=1 -> one result per cycle, results 0x0000000F then 0x000000FF for operands 0x0F/0xFF.
